// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the divide issue/stall controller.
//   div_op_e         : divide op encoding (DIV, DIVU, REM, REMU), same as req_op
//   div_seq_state_e  : controller state encoding
//   INT_MIN          : most negative 32-bit signed value
//   DIV_NOMINAL_LATENCY : accept-to-response cycles on the divider path
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } div_seq_state_e;

  localparam logic [31:0] INT_MIN             = 32'h8000_0000;
  localparam int unsigned DIV_NOMINAL_LATENCY = 37;

  // True for ops returning the quotient, false for ops returning the remainder.
  function automatic logic op_is_quotient(input div_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_special_case.sv
// -----------------------------------------------------------------------------
// div_special_case
// Combinational RISC-V divide corner-case table. Flags operand combinations
// whose result is architecturally fixed and supplies that result, so the
// controller can answer without starting the iterative divider.
//   op     in  2     divide op (div_op_e)
//   a      in  XLEN  dividend
//   b      in  XLEN  divisor
//   hit    out 1     operands form a special case
//   result out XLEN  fixed result when hit (0 otherwise)
// -----------------------------------------------------------------------------
module div_special_case
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  div_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic signed_overflow;

  assign signed_overflow = (a == MIN_NEG) && (b == '1);

  always_comb begin
    hit    = 1'b0;
    result = '0;
    if (b == '0) begin
      // Divide by zero: quotient is all-ones, remainder is the dividend.
      hit    = 1'b1;
      result = op_is_quotient(op) ? '1 : a;
    end else if (signed_overflow && (op == OP_DIV)) begin
      hit    = 1'b1;
      result = MIN_NEG;
    end else if (signed_overflow && (op == OP_REM)) begin
      hit    = 1'b1;
      result = '0;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Issue/stall controller between the execute stage and an iterative divider.
// Accepts one divide request at a time, stalls the pipeline, launches the
// divider, waits for its done pulse and returns the result with its rd.
// Divide-by-zero and signed overflow are answered locally one cycle after
// acceptance. Flushed in-flight divides are drained so the stale done pulse
// cannot be mistaken for a later request's result.
//
// Optional build macro: DIV_RESULT_CACHE_EN
//   When defined, a one-entry {op, a, b, result} cache answers a repeated
//   divider-path request one cycle after acceptance with no divider start.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid           divide instruction present in execute
//   req_op              00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b        dividend, divisor
//   req_rd              destination register
//   flush               kill the current request
//   stall               hold the pipeline (req_valid & ~resp_valid)
//   resp_valid          one-cycle result strobe
//   resp_data, resp_rd  result and its destination
//   div_start           one-cycle divider start pulse
//   div_op              divider op select
//   div_num, div_den    divider operands, stable from launch to done
//   div_result          divider result, valid with div_done
//   div_done            divider completion pulse
// -----------------------------------------------------------------------------
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            div_start,
  output logic [1:0]      div_op,
  output logic [XLEN-1:0] div_num,
  output logic [XLEN-1:0] div_den,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_done
);

  div_seq_state_e  state;
  logic            resp_valid_q;
  logic            from_div_q;

  logic            sc_hit;
  logic [XLEN-1:0] sc_result;

  logic            cache_hit;
  logic [XLEN-1:0] cache_result;

  div_special_case #(
    .XLEN (XLEN)
  ) u_special_case (
    .op     (div_op_e'(req_op)),
    .a      (req_a),
    .b      (req_b),
    .hit    (sc_hit),
    .result (sc_result)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid;
  logic [1:0]      cache_op;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic [XLEN-1:0] cache_res;

  // div_op/div_num/div_den still hold the launched operands while in RESP,
  // so they double as the cache tag source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_op    <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_res   <= '0;
    end else if ((state == S_RESP) && from_div_q && !flush) begin
      cache_valid <= 1'b1;
      cache_op    <= div_op;
      cache_a     <= div_num;
      cache_b     <= div_den;
      cache_res   <= resp_data;
    end
  end

  assign cache_hit    = cache_valid && (cache_op == req_op) &&
                        (cache_a == req_a) && (cache_b == req_b);
  assign cache_result = cache_res;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  // The strobe is registered, but a flush arriving in the RESP cycle itself
  // must still cancel it, hence the combinational gate.
  assign resp_valid = resp_valid_q & ~flush;
  assign stall      = req_valid & ~resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      resp_valid_q <= 1'b0;
      from_div_q   <= 1'b0;
      div_start    <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
      div_op       <= '0;
      div_num      <= '0;
      div_den      <= '0;
    end else begin
      div_start    <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            resp_rd <= req_rd;
            if (sc_hit) begin
              resp_data    <= sc_result;
              resp_valid_q <= 1'b1;
              from_div_q   <= 1'b0;
              state        <= S_RESP;
            end else if (cache_hit) begin
              resp_data    <= cache_result;
              resp_valid_q <= 1'b1;
              from_div_q   <= 1'b0;
              state        <= S_RESP;
            end else begin
              div_op    <= req_op;
              div_num   <= req_a;
              div_den   <= req_b;
              div_start <= 1'b1;
              state     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // The start pulse is already on the wire; a flush here can only
          // redirect us to drain the divider's eventual done.
          state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              resp_data    <= div_result;
              resp_valid_q <= 1'b1;
              from_div_q   <= 1'b1;
              state        <= S_RESP;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (div_done) begin
            state <= S_IDLE;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  import div_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;
  localparam int          LAT_DIV = 37;
  localparam int          LAT_SC  = 1;
  localparam int          TMO     = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic [1:0]      req_op = '0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            div_start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] div_num;
  logic [XLEN-1:0] div_den;
  logic [XLEN-1:0] div_result;
  logic            div_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rd     (req_rd),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .div_start  (div_start),
    .div_op     (div_op),
    .div_num    (div_num),
    .div_den    (div_den),
    .div_result (div_result),
    .div_done   (div_done)
  );

  // Divider model: no reset; done is high 35 cycles after the start cycle.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  logic        busy = 1'b0;
  int unsigned cnt  = 0;
  logic [31:0] res_q = '0;

  always @(posedge clk) begin
    if (div_start) begin
      busy  <= 1'b1;
      cnt   <= 34;
      res_q <= ref_div(div_op, div_num, div_den);
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  assign div_done   = busy && (cnt == 0);
  assign div_result = res_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Presents a request in the current cycle and follows it to its response.
  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat, input int starts);
    int st = 0;
    int stall_cyc = 0;
    int seen = -1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    #1;
    for (int i = 0; i <= TMO; i++) begin
      if (resp_valid) begin
        seen = i;
        break;
      end
      if (div_start) st++;
      if (stall) stall_cyc++;
      next_cycle();
    end
    check({name, "_resp_seen"}, 32'(seen >= 0), 32'd1);
    check({name, "_latency"}, 32'(seen), 32'(lat));
    check({name, "_data"}, resp_data, exp);
    check({name, "_rd"}, 32'(resp_rd), 32'(rd));
    check({name, "_starts"}, 32'(st), 32'(starts));
    check({name, "_stall_cycles"}, 32'(stall_cyc), 32'(lat));
    req_valid = 1'b0;
    next_cycle();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    int          starts;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_resp;
    int n_start;
    int n_done;
    int k;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          5'd5,  32'd14,         LAT_DIV, 1};
    vecs[1]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd1,  32'h8000_0000,  LAT_SC,  0};
    vecs[2]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  5'd2,  32'h0,          LAT_SC,  0};
    vecs[3]  = '{2'd0, 32'd5,          32'd0,          5'd3,  32'hFFFF_FFFF,  LAT_SC,  0};
    vecs[4]  = '{2'd3, 32'd5,          32'd0,          5'd4,  32'd5,          LAT_SC,  0};
    vecs[5]  = '{2'd0, 32'd20,         32'd6,          5'd10, 32'd3,          LAT_DIV, 1};
    vecs[6]  = '{2'd2, 32'd20,         32'd6,          5'd11, 32'd2,          LAT_DIV, 1};
    vecs[7]  = '{2'd0, 32'hFFFF_FFEC,  32'd6,          5'd12, 32'hFFFF_FFFD,  LAT_DIV, 1};
    vecs[8]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          5'd13, 32'hFFFF_FFFF,  LAT_DIV, 1};
    vecs[9]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0,          LAT_DIV, 1};
    vecs[10] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  LAT_DIV, 1};
    vecs[11] = '{2'd2, 32'd7,          32'd0,          5'd31, 32'd7,          LAT_SC,  0};
    vecs[12] = '{2'd1, 32'hFFFF_FFFF,  32'd0,          5'd0,  32'hFFFF_FFFF,  LAT_SC,  0};
    vecs[13] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd16, 32'd1,          LAT_DIV, 1};

    // Reset state
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", 32'(resp_rd), 32'd0);
    check("rst_div_num", div_num, 32'd0);
    check("rst_div_den", div_den, 32'd0);
    check("rst_div_op", 32'(div_op), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Table: consecutive entries are presented back-to-back
    for (int i = 0; i < 14; i++)
      do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat, vecs[i].starts);

    // Repeat of a divider-path request
    do_req("cache_first", 2'd0, 32'd20, 32'd6, 5'd6, 32'd3, LAT_DIV, 1);
`ifdef DIV_RESULT_CACHE_EN
    do_req("cache_repeat", 2'd0, 32'd20, 32'd6, 5'd7, 32'd3, LAT_SC, 0);
`else
    do_req("cache_repeat", 2'd0, 32'd20, 32'd6, 5'd7, 32'd3, LAT_DIV, 1);
`endif

    // Flush in WAIT at T0+10, new DIVU 9/3 presented during DRAIN
    req_valid = 1'b1; req_op = 2'd2; req_a = 32'hFFFF_FFF9; req_b = 32'd2; req_rd = 5'd7;
    #1;
    n_resp = 0; n_start = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) n_resp++;
      if (div_start) n_start++;
      next_cycle();
    end
    flush = 1'b1; req_valid = 1'b0;
    #1;
    if (resp_valid) n_resp++;
    next_cycle();
    flush = 1'b0;
    check("drain_pre_starts", 32'(n_start), 32'd1);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd9; req_b = 32'd3; req_rd = 5'd9;
    #1;
    k = -1; n_start = 0;
    for (int i = 0; i <= TMO; i++) begin
      if (resp_valid) begin
        k = i;
        break;
      end
      if (div_start) n_start++;
      next_cycle();
    end
    check("drain_no_stale_resp", 32'(n_resp), 32'd0);
    check("drain_new_latency", 32'(k), 32'd63);
    check("drain_new_data", resp_data, 32'd3);
    check("drain_new_rd", 32'(resp_rd), 32'd9);
    check("drain_new_starts", 32'(n_start), 32'd1);
    req_valid = 1'b0;
    next_cycle();

    // Flush in RESP of a special case
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd5; req_b = 32'd0; req_rd = 5'd3;
    #1;
    next_cycle();
    check("resp_flush_pre", 32'(resp_valid), 32'd1);
    flush = 1'b1; req_valid = 1'b0;
    #1;
    check("resp_flush_suppress", 32'(resp_valid), 32'd0);
    next_cycle();
    flush = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) n_resp++;
      next_cycle();
    end
    check("resp_flush_after", 32'(n_resp), 32'd0);

    // Flush together with req_valid in IDLE
    req_valid = 1'b1; flush = 1'b1; req_op = 2'd1; req_a = 32'd100; req_b = 32'd7;
    #1;
    next_cycle();
    req_valid = 1'b0; flush = 1'b0;
    n_resp = 0; n_start = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) n_resp++;
      if (div_start) n_start++;
      next_cycle();
    end
    check("idle_flush_resp", 32'(n_resp), 32'd0);
    check("idle_flush_starts", 32'(n_start), 32'd0);

    // Flush in LAUNCH: start still issued, done drained
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd8;
    #1;
    next_cycle();
    flush = 1'b1; req_valid = 1'b0;
    #1;
    check("launch_flush_start", 32'(div_start), 32'd1);
    next_cycle();
    flush = 1'b0;
    n_resp = 0; n_done = 0;
    for (int i = 0; i < 45; i++) begin
      if (resp_valid) n_resp++;
      if (div_done) n_done++;
      next_cycle();
    end
    check("launch_flush_resp", 32'(n_resp), 32'd0);
    check("launch_flush_done", 32'(n_done), 32'd1);
    do_req("after_launch_flush", 2'd0, 32'd5, 32'd0, 5'd2, 32'hFFFF_FFFF, LAT_SC, 0);

    // Flush coincident with div_done in WAIT: straight back to IDLE
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd3;
    #1;
    for (int i = 0; i < 36; i++) next_cycle();
    check("coinc_done_present", 32'(div_done), 32'd1);
    flush = 1'b1; req_valid = 1'b0;
    #1;
    next_cycle();
    flush = 1'b0;
    check("coinc_no_resp", 32'(resp_valid), 32'd0);
    do_req("after_coinc", 2'd3, 32'd5, 32'd0, 5'd4, 32'd5, LAT_SC, 0);

    // Asynchronous reset in WAIT, stray done afterwards
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd21;
    #1;
    for (int i = 0; i < 10; i++) next_cycle();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_div_start", 32'(div_start), 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    check("arst_resp_rd", 32'(resp_rd), 32'd0);
    check("arst_div_num", div_num, 32'd0);
    check("arst_div_den", div_den, 32'd0);
    check("arst_div_op", 32'(div_op), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    n_resp = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) n_resp++;
      if (div_done) n_done++;
      next_cycle();
    end
    check("stray_done_seen", 32'(n_done), 32'd1);
    check("stray_done_no_resp", 32'(n_resp), 32'd0);
    do_req("after_reset", 2'd1, 32'd9, 32'd3, 5'd22, 32'd3, LAT_DIV, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
